// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Handshaked ALU execution unit. Single-cycle arithmetic, logic,
//            compare and branch-condition ops; serial one-bit-per-cycle shifts.
// Revision : 1.0 - initial release
// ============================================================================

module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] c_add  = 4'b0000;
  localparam logic [3:0] c_sub  = 4'b0001;
  localparam logic [3:0] c_xor  = 4'b0010;
  localparam logic [3:0] c_or   = 4'b0011;
  localparam logic [3:0] c_and  = 4'b0100;
  localparam logic [3:0] c_sll  = 4'b0101;
  localparam logic [3:0] c_srl  = 4'b0110;
  localparam logic [3:0] c_sra  = 4'b0111;
  localparam logic [3:0] c_slt  = 4'b1000;
  localparam logic [3:0] c_sltu = 4'b1001;
  localparam logic [3:0] c_beq  = 4'b1010;
  localparam logic [3:0] c_bne  = 4'b1011;
  localparam logic [3:0] c_blt  = 4'b1100;
  localparam logic [3:0] c_bge  = 4'b1101;
  localparam logic [3:0] c_bltu = 4'b1110;
  localparam logic [3:0] c_bgeu = 4'b1111;

  // Shift kind is the low two bits of the shift codes (01 sll, 10 srl, 11 sra)
  localparam logic [1:0] c_kind_sll = 2'b01;
  localparam logic [1:0] c_kind_srl = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_acc;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_shift_kind;
  logic [XLEN-1:0] r_result;
  logic            r_branch_taken;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_is_shift;
  logic [SHW-1:0]  w_shamt;
  logic            w_go_shift;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [XLEN-1:0] w_alu_res;
  logic            w_taken;
  logic [XLEN-1:0] w_acc_step;
  logic            w_last_shift;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_is_shift   = (ctrl == c_sll) || (ctrl == c_srl) || (ctrl == c_sra);
  assign w_shamt      = op_b[SHW-1:0];
  assign w_go_shift   = w_is_shift && (w_shamt != '0);
  assign w_last_shift = (r_state == SHIFT) && (r_cnt == SHW'(1));

  assign w_eq   = (op_a == op_b);
  assign w_lt_s = ($signed(op_a) < $signed(op_b));
  assign w_lt_u = (op_a < op_b);

  // Single-cycle function; shift codes pass op_a through for the shamt-0 case
  always_comb begin
    w_alu_res = '0;
    w_taken   = 1'b0;
    case (ctrl)
      c_add:  w_alu_res = op_a + op_b;
      c_sub:  w_alu_res = op_a - op_b;
      c_xor:  w_alu_res = op_a ^ op_b;
      c_or:   w_alu_res = op_a | op_b;
      c_and:  w_alu_res = op_a & op_b;
      c_sll,
      c_srl,
      c_sra:  w_alu_res = op_a;
      c_slt:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
      c_sltu: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
      c_beq:  w_taken   = w_eq;
      c_bne:  w_taken   = !w_eq;
      c_blt:  w_taken   = w_lt_s;
      c_bge:  w_taken   = !w_lt_s;
      c_bltu: w_taken   = w_lt_u;
      c_bgeu: w_taken   = !w_lt_u;
      default: w_alu_res = '0;
    endcase
    if (ctrl[3] && (ctrl[2] || ctrl[1])) begin
      w_alu_res = {{(XLEN-1){1'b0}}, w_taken};
    end
  end

  always_comb begin
    w_acc_step = r_acc;
    case (r_shift_kind)
      c_kind_sll: w_acc_step = {r_acc[XLEN-2:0], 1'b0};
      c_kind_srl: w_acc_step = {1'b0, r_acc[XLEN-1:1]};
      default:    w_acc_step = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_go_shift ? SHIFT : HOLD;
        end
      end
      SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_shift_kind   <= '0;
      r_result       <= '0;
      r_branch_taken <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == HOLD);
      if (w_accept) begin
        r_acc          <= op_a;
        r_cnt          <= w_shamt;
        r_shift_kind   <= ctrl[1:0];
        r_branch_taken <= w_taken;
        if (!w_go_shift) begin
          r_result <= w_alu_res;
        end
      end else if (r_state == SHIFT) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - SHW'(1);
        if (w_last_shift) begin
          r_result <= w_acc_step;
        end
      end
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign branch_taken = r_branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed plus randomized checks of alu_exec_unit against a model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ctrl         (ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {taken, result} straight from the operation table
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    int          sh;
    sh = int'(b[4:0]);
    r  = 32'd0;
    t  = 1'b0;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = $unsigned($signed(a) >>> sh);
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: t = (a == b);
      4'd11: t = (a != b);
      4'd12: t = ($signed(a) < $signed(b));
      4'd13: t = ($signed(a) >= $signed(b));
      4'd14: t = (a < b);
      default: t = (a >= b);
    endcase
    if (c >= 4'd10) r = {31'd0, t};
    return {t, r};
  endfunction

  function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
    if (c == 4'd5 || c == 4'd6 || c == 4'd7) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [32:0] exp;
    int          exp_lat;
    int          lat;
    exp     = model(c, a, b);
    exp_lat = model_latency(c, b);
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ctrl     = c;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    // Operands change after acceptance and must be ignored
    in_valid = 1'b0;
    ctrl     = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat = 1;
    while (!out_valid && lat < XLEN + 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, result, exp[31:0]);
    chk({tag, ".branch"}, {31'd0, branch_taken}, {31'd0, exp[32]});
    chk({tag, ".busy_in_ready"}, {30'd0, busy, in_ready}, 32'b10);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      ctrl     = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      chk({tag, ".stall_result"}, result, exp[31:0]);
      chk({tag, ".stall_flags"}, {30'd0, out_valid, in_ready}, 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'b01);
    if (stall > 0) begin
      @(negedge clk);
      chk({tag, ".not_queued"}, {30'd0, out_valid, busy}, 32'b00);
    end
  endtask

  initial begin
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctrl      = 4'd0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(negedge clk);
    chk("reset.result", result, 32'd0);
    chk("reset.flags", {29'd0, out_valid, branch_taken, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Wrap-around arithmetic
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub_wrap", 4'd1, 32'd0, 32'd1, 0);

    // Serial shifts incl. longest and upper op_b bits discarded
    run_op("sra31", 4'd7, 32'h8000_0000, 32'h0000_001F, 0);
    run_op("srl31", 4'd6, 32'h8000_0000, 32'h0000_001F, 0);
    run_op("sll4", 4'd5, 32'd1, 32'hFFFF_FF04, 0);
    run_op("sll0", 4'd5, 32'h1234_5678, 32'h0000_0020, 0);

    // Compares and branches; add afterwards clears branch_taken
    run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("blt", 4'd12, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("bltu", 4'd14, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("beq", 4'd10, 32'd7, 32'd7, 0);
    run_op("add_clr", 4'd0, 32'd3, 32'd4, 0);

    // Backpressure with ignored in_valid during the stall
    run_op("stall", 4'd2, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 10);

    // Reset in the middle of a shift abandons it
    @(negedge clk);
    in_valid = 1'b1;
    ctrl     = 4'd5;
    op_a     = 32'h0000_0003;
    op_b     = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset.result", result, 32'd0);
    chk("midreset.flags", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset.in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midreset.stale", 32'(stale), 32'd0);

    // Randomized operations against the model
    for (int k = 0; k < 60; k++) begin
      run_op("rand", 4'($urandom), $urandom, $urandom, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Handshaked execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and executes the selected operation on two operands. Arithmetic, logic, compare and branch-condition ops complete in one cycle. Shifts run serially, one bit per cycle, to save area. It sits between decode/register-read and writeback/PC-select, and returns a registered result plus a branch-taken flag through a valid/ready pair.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept (high only in IDLE)
- ctrl  input  4  ALU control code: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu, 1010 beq, 1011 bne, 1100 blt, 1101 bge, 1110 bltu, 1111 bgeu
- op_a  input  XLEN  operand A (shift source)
- op_b  input  XLEN  operand B; for shifts only op_b[SHW-1:0] is used
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- branch_taken  output  1  registered branch condition; 0 for non-branch codes
- busy  output  1  state != IDLE

## Operation
- States: IDLE, SHIFT, HOLD. Reset → IDLE.
- Acceptance: in_valid && in_ready in IDLE. ctrl/op_a/op_b are sampled only at acceptance; later changes are ignored.
- Non-shift code at acceptance: result ← f(op_a, op_b); IDLE → HOLD.
  - add/sub: modulo 2^XLEN, no flags.
  - slt: signed compare. sltu: unsigned compare. Result is {0…, lt}.
  - Branch codes: result ← {0…, taken}; branch_taken ← taken.
  - Branch conditions: beq a==b; bne a!=b; blt signed a<b; bge signed a≥b; bltu unsigned a<b; bgeu unsigned a≥b.
- Shift code at acceptance:
  - Loads acc ← op_a and cnt ← op_b[SHW-1:0]; branch_taken ← 0.
  - cnt == 0: result ← op_a; go to HOLD.
  - cnt != 0: go to SHIFT.
- SHIFT, each cycle:
  - acc shifted by 1: sll fills 0 from the LSB; srl fills 0 from the MSB; sra replicates acc[XLEN-1].
  - cnt ← cnt−1.
  - On the cycle where cnt == 1: result ← shifted acc; go to HOLD.
- HOLD: out_valid = 1; result and branch_taken are held stable. On out_ready → IDLE.
- out_valid is registered: it is high exactly in HOLD, and is never asserted in the same cycle as in_ready.
- branch_taken is cleared to 0 on acceptance of any non-branch code.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state IDLE; result 0; branch_taken 0; out_valid 0; busy 0.
  - in_ready = 1 once rst_n is high.
- Latency, measured from the acceptance cycle c to the first out_valid cycle:
  - 1 cycle for non-shift codes and for shamt 0.
  - 1+shamt cycles for shifts; maximum XLEN.
- Minimum issue interval is 2 cycles: the HOLD cycle with out_ready=1 is followed by IDLE.
- Backpressure: out_ready low holds HOLD indefinitely; in_ready stays 0 for the whole stall.
- Reset mid-SHIFT or mid-HOLD abandons the operation: no out_valid pulse, state returns to IDLE, result returns to 0.
- in_valid while busy: ignored, not queued.
- shamt ≥ XLEN is impossible by width (upper op_b bits are discarded); the shift by 31 at XLEN=32 takes 32 cycles.

## Test plan
- Reset: hold rst_n low mid-SHIFT (sll, shamt 20, cycle 5) → out_valid 0, result 0, busy 0 immediately; after release in_ready=1, no stale output.
- add/sub wrap: ctrl 0000, a=FFFFFFFF, b=1 → result 0 at cycle c+1. ctrl 0001, a=0, b=1 → FFFFFFFF.
- Shifts: sra a=80000000, b=0000001F → result FFFFFFFF after exactly 32 cycles. srl same operands → 00000001. sll a=1, b=FFFFFF04 → 00000010 at c+5.
- shamt 0: sll a=12345678, b=20 → result 12345678 at c+1.
- Compares/branches:
  - slt a=FFFFFFFF, b=1 → 1; sltu same → 0.
  - blt a=-1, b=0 → branch_taken 1; bltu same → 0; beq a=b=7 → 1.
  - A following add clears branch_taken.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → result and out_valid stable, in_ready 0, new in_valid ignored. Release → one transfer, then IDLE.
